// File: rtl/slave_rx_port.sv
// Serial LSB-first address/data receive port for the bus slave side.
// Optional parity check on the trailing bit is enabled with `define SLAVE_RX_PARITY_EN.
module slave_rx_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_address,
  input  logic                  rx_data,
  input  logic                  master_valid,
  input  logic                  read_en,
  input  logic                  write_en,
  output logic                  slave_ready,
  output logic                  rx_done,
  output logic                  rx_write,
  output logic                  rx_error,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data
);

  localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW    = $clog2(MAX_W + 2);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, last_idx;
  logic                  is_write;
  logic [ADDR_WIDTH-1:0] addr_sr, addr_nxt;
  logic [DATA_WIDTH-1:0] data_sr, data_nxt;
  logic                  handshake, last_bit;

  assign slave_ready = (state == IDLE);
  assign handshake   = master_valid & slave_ready & (read_en | write_en);
  assign last_idx    = is_write ? CW'(MAX_W - 1) : CW'(ADDR_WIDTH - 1);
  assign last_bit    = (cnt == last_idx);

  // Shift registers with the current bit merged in, so the final bit can be
  // committed to the outputs on the same edge it is sampled.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    addr_nxt = addr_sr;
    data_nxt = data_sr;
    for (int i = 0; i < ADDR_WIDTH; i++)
      if (cnt == CW'(i)) addr_nxt[i] = rx_address;
    for (int i = 0; i < DATA_WIDTH; i++)
      if (is_write && cnt == CW'(i)) data_nxt[i] = rx_data;
  end

`ifdef SLAVE_RX_PARITY_EN
  logic err_q, par_ok;
  assign par_ok   = (rx_address == ^addr_sr) && (!is_write || (rx_data == ^data_sr));
  assign rx_done  = (state == DONE) && !err_q;
  assign rx_error = (state == DONE) &&  err_q;
`else
  assign rx_done  = (state == DONE);
  assign rx_error = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (handshake) state_nxt = SHIFT;
`ifdef SLAVE_RX_PARITY_EN
      SHIFT:  if (last_bit) state_nxt = PARITY;
      PARITY: state_nxt = DONE;
`else
      SHIFT:  if (last_bit) state_nxt = DONE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: only flops live here (no memory array), so everything is cleared on reset.
    if (reset) begin
      cnt      <= '0;
      is_write <= 1'b0;
      addr_sr  <= '0;
      data_sr  <= '0;
      address  <= '0;
      data     <= '0;
      rx_write <= 1'b0;
`ifdef SLAVE_RX_PARITY_EN
      err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (handshake) begin
          is_write <= write_en;
          cnt      <= '0;
          addr_sr  <= '0;
          data_sr  <= '0;
`ifdef SLAVE_RX_PARITY_EN
          err_q    <= 1'b0;
`endif
        end
        SHIFT: begin
          addr_sr <= addr_nxt;
          data_sr <= data_nxt;
          cnt     <= cnt + CW'(1);
`ifndef SLAVE_RX_PARITY_EN
          if (last_bit) begin
            address  <= addr_nxt;
            if (is_write) data <= data_nxt;
            rx_write <= is_write;
          end
`endif
        end
`ifdef SLAVE_RX_PARITY_EN
        PARITY: begin
          if (par_ok) begin
            address  <= addr_sr;
            if (is_write) data <= data_sr;
            rx_write <= is_write;
          end else begin
            err_q <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_slave_rx_port.sv
// Randomized self-checking bench for slave_rx_port: default 12/8 instance plus a 4/16 instance.
module tb_slave_rx_port;

`ifdef SLAVE_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic rx_address, rx_data, read_en, write_en;
  logic mv_a, mv_b;

  logic        ready_a, done_a, wr_a, err_a;
  logic [11:0] address_a;
  logic [7:0]  data_a;
  logic        ready_b, done_b, wr_b, err_b;
  logic [3:0]  address_b;
  logic [15:0] data_b;

  int checks = 0;
  int errors = 0;

  // Reference model: last committed transaction per instance.
  logic [15:0] exp_a [2];
  logic [15:0] exp_d [2];
  bit          exp_w [2];

  bit          cur;
  logic        o_ready, o_done, o_err, o_wr;
  logic [15:0] o_addr, o_data;

  always #5 clk = ~clk;

  slave_rx_port dut_a (
    .clk(clk), .reset(reset), .rx_address(rx_address), .rx_data(rx_data),
    .master_valid(mv_a), .read_en(read_en), .write_en(write_en),
    .slave_ready(ready_a), .rx_done(done_a), .rx_write(wr_a), .rx_error(err_a),
    .address(address_a), .data(data_a)
  );

  slave_rx_port #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) dut_b (
    .clk(clk), .reset(reset), .rx_address(rx_address), .rx_data(rx_data),
    .master_valid(mv_b), .read_en(read_en), .write_en(write_en),
    .slave_ready(ready_b), .rx_done(done_b), .rx_write(wr_b), .rx_error(err_b),
    .address(address_b), .data(data_b)
  );

  always_comb begin
    o_ready = cur ? ready_b : ready_a;
    o_done  = cur ? done_b  : done_a;
    o_err   = cur ? err_b   : err_a;
    o_wr    = cur ? wr_b    : wr_a;
    o_addr  = cur ? {12'b0, address_b} : {4'b0, address_a};
    o_data  = cur ? data_b : {8'b0, data_a};
  end

  task automatic clear_model();
    for (int s = 0; s < 2; s++) begin
      exp_a[s] = '0;
      exp_d[s] = '0;
      exp_w[s] = 1'b0;
    end
  endtask

  // One complete transaction; entered and left at #1 after an edge with the DUT in IDLE,
  // so consecutive calls exercise minimum handshake spacing.
  task automatic do_txn(input string name, input bit sel, input bit rd, input bit wr,
                        input logic [15:0] a, input logic [15:0] d, input bit bad_par);
    int aw, dw, len;
    bit exp_bad, early, par_a, par_d;
    aw = sel ? 4 : 12;
    dw = sel ? 16 : 8;
    len = wr ? ((aw > dw) ? aw : dw) : aw;
    exp_bad = bad_par && PAR;
    par_a = 1'b0;
    par_d = 1'b0;
    for (int i = 0; i < aw; i++) par_a ^= a[i];
    for (int i = 0; i < dw; i++) par_d ^= d[i];
    cur = sel;
    if (sel) mv_b = 1'b1; else mv_a = 1'b1;
    read_en  = rd;
    write_en = wr;
    @(posedge clk); #1;
    mv_a = 1'b0; mv_b = 1'b0;
    read_en  = 1'($urandom);
    write_en = 1'($urandom);
    checks++;
    if (o_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_after_handshake got %b want 0", name, o_ready);
    end
    early = 1'b0;
    for (int i = 0; i < len; i++) begin
      rx_address = (i < aw) ? a[i] : 1'($urandom);
      rx_data    = (wr && i < dw) ? d[i] : 1'($urandom);
      @(posedge clk); #1;
      if (i < len - 1 || PAR)
        if (o_done !== 1'b0 || o_err !== 1'b0 || o_addr !== exp_a[sel] || o_data !== exp_d[sel])
          early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL %s mid_shift_visible got early strobe/output change want none", name);
    end
    if (PAR) begin
      rx_address = par_a ^ bad_par;
      rx_data    = wr ? par_d : 1'($urandom);
      @(posedge clk); #1;
    end
    if (!exp_bad) begin
      exp_a[sel] = a & ((16'd1 << aw) - 16'd1);
      if (wr) exp_d[sel] = d & ((sel ? 17'h10000 : 17'h100) - 17'd1);
      exp_w[sel] = wr;
    end
    checks++;
    if (o_done !== !exp_bad) begin
      errors++;
      $display("FAIL %s rx_done got %b want %b", name, o_done, !exp_bad);
    end
    checks++;
    if (o_err !== exp_bad) begin
      errors++;
      $display("FAIL %s rx_error got %b want %b", name, o_err, exp_bad);
    end
    checks++;
    if (o_addr !== exp_a[sel]) begin
      errors++;
      $display("FAIL %s address got %h want %h", name, o_addr, exp_a[sel]);
    end
    checks++;
    if (o_data !== exp_d[sel]) begin
      errors++;
      $display("FAIL %s data got %h want %h", name, o_data, exp_d[sel]);
    end
    checks++;
    if (o_wr !== exp_w[sel]) begin
      errors++;
      $display("FAIL %s rx_write got %b want %b", name, o_wr, exp_w[sel]);
    end
    rx_address = 1'b0;
    rx_data    = 1'b0;
    read_en    = 1'b0;
    write_en   = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (o_done !== 1'b0 || o_err !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s back_to_idle got done=%b err=%b ready=%b want 0 0 1",
               name, o_done, o_err, o_ready);
    end
  endtask

  task automatic check_cleared(input string name);
    checks++;
    if (ready_a !== 1'b1 || done_a !== 1'b0 || wr_a !== 1'b0 || err_a !== 1'b0 ||
        address_a !== 12'h0 || data_a !== 8'h0) begin
      errors++;
      $display("FAIL %s dut_a got rdy=%b done=%b wr=%b err=%b a=%h d=%h want 1 0 0 0 000 00",
               name, ready_a, done_a, wr_a, err_a, address_a, data_a);
    end
    checks++;
    if (ready_b !== 1'b1 || done_b !== 1'b0 || wr_b !== 1'b0 || err_b !== 1'b0 ||
        address_b !== 4'h0 || data_b !== 16'h0) begin
      errors++;
      $display("FAIL %s dut_b got rdy=%b done=%b wr=%b err=%b a=%h d=%h want 1 0 0 0 0 0000",
               name, ready_b, done_b, wr_b, err_b, address_b, data_b);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_address = 1'b0; rx_data = 1'b0; read_en = 1'b0; write_en = 1'b0;
    mv_a = 1'b0; mv_b = 1'b0; cur = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check_cleared("reset_values");
  endtask

  task automatic test_write();
    do_txn("write_a5c_3e", 1'b0, 1'b0, 1'b1, 16'h0A5C, 16'h003E, 1'b0);
  endtask

  task automatic test_read();
    do_txn("read_123", 1'b0, 1'b1, 1'b0, 16'h0123, 16'hFFFF, 1'b0);
  endtask

  task automatic test_reset_mid_shift();
    cur = 1'b0;
    mv_a = 1'b1; write_en = 1'b1; read_en = 1'b0;
    @(posedge clk); #1;
    mv_a = 1'b0; write_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rx_address = 1'($urandom);
      rx_data    = 1'($urandom);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    clear_model();
    @(posedge clk); #1;
    check_cleared("reset_mid_shift");
    reset = 1'b0;
    @(posedge clk); #1;
    do_txn("write_after_reset", 1'b0, 1'b0, 1'b1, 16'h0A5C, 16'h003E, 1'b0);
  endtask

  task automatic test_no_enable();
    bit bad;
    cur = 1'b0;
    bad = 1'b0;
    mv_a = 1'b1; read_en = 1'b0; write_en = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ready_a !== 1'b1 || done_a !== 1'b0) bad = 1'b1;
    end
    mv_a = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL no_enable left idle or strobed ready=%b done=%b want 1 0", ready_a, done_a);
    end
    do_txn("after_no_enable_read", 1'b0, 1'b1, 1'b0, 16'h0777, 16'h0000, 1'b0);
  endtask

  task automatic test_priority();
    do_txn("both_enables_write", 1'b0, 1'b1, 1'b1, 16'h0F0F, 16'h00C3, 1'b0);
  endtask

  task automatic test_param_sweep();
    do_txn("w4_16_write", 1'b1, 1'b0, 1'b1, 16'h0009, 16'hBEEF, 1'b0);
    do_txn("w4_16_back_to_back", 1'b1, 1'b0, 1'b1, 16'h0006, 16'h1234, 1'b0);
    do_txn("w4_16_read", 1'b1, 1'b1, 1'b0, 16'h000C, 16'h5555, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      bit sel, rd, wr;
      sel = 1'($urandom);
      case ($urandom_range(0, 2))
        0: begin rd = 1'b1; wr = 1'b0; end
        1: begin rd = 1'b0; wr = 1'b1; end
        default: begin rd = 1'b1; wr = 1'b1; end
      endcase
      do_txn($sformatf("random_%0d", n), sel, rd, wr, 16'($urandom), 16'($urandom), 1'b0);
    end
  endtask

  task automatic test_parity();
    do_txn("parity_bad_addr", 1'b0, 1'b0, 1'b1, 16'h0001, 16'h005A, 1'b1);
    do_txn("parity_good", 1'b0, 1'b0, 1'b1, 16'h0001, 16'h005A, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_reset_mid_shift();
    test_no_enable();
    test_priority();
    test_param_sweep();
    test_random();
    test_parity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
